// File: rtl/calc_controller_gen2_pkg.sv
// Shared types and defaults for the gen2 calculator controller.
// Holds the FSM state encoding and key defaults.
package calc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_MODE,
    ST_MEM,
    ST_SAMPLE,
    ST_TX
  } ctrl_state_t;

  localparam int DEF_KEY_LEN = 4;
  localparam logic [3:0] DEF_KEY_PATTERN = 4'b1010;

  // Counter width able to hold n, never below one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/calc_controller_gen2_if.sv
// Command/status bundle between the front end and the controller.
// master drives commands, slave is the controller.
interface calc_controller_gen2_if #(
  parameter int MODE_W = 1
);
  logic              inputKey;
  logic              validCmd;
  logic              RW;
  logic              txDone;
  logic              active;
  logic [MODE_W-1:0] mode;
  logic              AccessMem;
  logic              RWMem;
  logic              SampleData;
  logic              TxData;
  logic              Busy;
  logic              keyErr;
  logic              txTimeout;

  modport master (
    output inputKey, validCmd, RW, txDone,
    input  active, mode, AccessMem, RWMem,
    input  SampleData, TxData, Busy,
    input  keyErr, txTimeout
  );

  modport slave (
    input  inputKey, validCmd, RW, txDone,
    output active, mode, AccessMem, RWMem,
    output SampleData, TxData, Busy,
    output keyErr, txTimeout
  );
endinterface

// File: rtl/calc_controller_gen2_key_matcher.sv
// Serial key shifter and comparator, MSB first.
// done/match are valid on the edge that takes the last bit.
module calc_key_matcher
  import calc_ctrl_pkg::*;
#(
  parameter int                 KEY_LEN     = DEF_KEY_LEN,
  parameter logic [KEY_LEN-1:0] KEY_PATTERN = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic bit_in,
  output logic done,
  output logic match
);
  localparam int KCW = cnt_w(KEY_LEN);
  localparam logic [KCW-1:0] K_LAST = KCW'(KEY_LEN - 1);

  logic [KEY_LEN-1:0] sr_q, sr_d, key_next;
  logic [KCW-1:0]     cnt_q, cnt_d;

  assign key_next = KEY_LEN'({sr_q, bit_in});
  assign done     = shift_en && (cnt_q == K_LAST);
  assign match    = (key_next == KEY_PATTERN);

  // Any gap in shifting discards the partial key.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (!shift_en || done) begin
      sr_d  = '0;
      cnt_d = '0;
    end else begin
      sr_d  = key_next;
      cnt_d = cnt_q + KCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/calc_controller_gen2.sv
// Gen2 calculator control FSM: key check, mode latch,
// memory or sample step, then TX handshake with timeout.
module calc_controller_gen2
  import calc_ctrl_pkg::*;
#(
  parameter int                 KEY_LEN     = DEF_KEY_LEN,
  parameter logic [KEY_LEN-1:0] KEY_PATTERN = DEF_KEY_PATTERN,
  parameter int                 MODE_W      = 1,
  parameter int                 TX_TIMEOUT  = 16
) (
  input logic                  clk,
  input logic                  reset,
  calc_controller_gen2_if.slave bus
);
  localparam int MCW = cnt_w(MODE_W);
  localparam int TCW = cnt_w(TX_TIMEOUT);
  localparam logic [MCW-1:0] M_LAST = MCW'(MODE_W - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TX_TIMEOUT - 1);
  localparam logic [TCW-1:0] T_MAX  = '1;

  ctrl_state_t state_q, state_d;

  logic              key_shift, key_done, key_match;
  logic [MODE_W-1:0] msr_q, msr_d, mode_q, mode_d, mode_cap;
  logic [MCW-1:0]    mcnt_q, mcnt_d;
  logic [TCW-1:0]    tcnt_q, tcnt_d;
  logic              rwmem_q, rwmem_d;
  logic              kerr_q, kerr_d;
  logic              tto_q, tto_d;
  logic              active_q, active_d;
  logic              amem_q, amem_d;
  logic              samp_q, samp_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;

  assign key_shift = bus.validCmd &&
    (state_q == ST_IDLE || state_q == ST_KEY);
  assign mode_cap  = MODE_W'({msr_q, bus.inputKey});

  calc_key_matcher #(
    .KEY_LEN    (KEY_LEN),
    .KEY_PATTERN(KEY_PATTERN)
  ) u_key (
    .clk     (clk),
    .reset   (reset),
    .shift_en(key_shift),
    .bit_in  (bus.inputKey),
    .done    (key_done),
    .match   (key_match)
  );

  always_comb begin
    state_d = state_q;
    msr_d   = msr_q;
    mcnt_d  = mcnt_q;
    tcnt_d  = tcnt_q;
    mode_d  = mode_q;
    rwmem_d = rwmem_q;
    kerr_d  = 1'b0;
    tto_d   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_KEY: begin
        if (!bus.validCmd) begin
          state_d = ST_IDLE;
        end else if (key_done) begin
          state_d = key_match ? ST_MODE : ST_IDLE;
          kerr_d  = !key_match;
          msr_d   = '0;
          mcnt_d  = '0;
        end else begin
          state_d = ST_KEY;
        end
      end
      ST_MODE: begin
        if (!bus.validCmd) begin
          state_d = ST_IDLE;
        end else if (mcnt_q == M_LAST) begin
          mode_d  = mode_cap;
          rwmem_d = bus.RW;
          state_d = (|mode_cap) ? ST_MEM : ST_SAMPLE;
        end else begin
          msr_d  = mode_cap;
          mcnt_d = mcnt_q + MCW'(1);
        end
      end
      ST_MEM: begin
        state_d = rwmem_q ? ST_IDLE : ST_TX;
        tcnt_d  = '0;
      end
      ST_SAMPLE: begin
        state_d = ST_TX;
        tcnt_d  = '0;
      end
      ST_TX: begin
        // txDone takes priority over an expiring timeout.
        if (bus.txDone) begin
          state_d = ST_IDLE;
        end else if (TX_TIMEOUT > 0 && tcnt_q == T_LAST) begin
          state_d = ST_IDLE;
          tto_d   = 1'b1;
        end else if (tcnt_q != T_MAX) begin
          tcnt_d = tcnt_q + TCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    active_d = (state_d == ST_MEM) ||
               (state_d == ST_SAMPLE) ||
               (state_d == ST_TX);
    amem_d   = (state_d == ST_MEM);
    samp_d   = (state_d == ST_SAMPLE);
    txd_d    = (state_d == ST_TX);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      msr_q    <= '0;
      mcnt_q   <= '0;
      tcnt_q   <= '0;
      mode_q   <= '0;
      rwmem_q  <= 1'b0;
      kerr_q   <= 1'b0;
      tto_q    <= 1'b0;
      active_q <= 1'b0;
      amem_q   <= 1'b0;
      samp_q   <= 1'b0;
      txd_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      msr_q    <= msr_d;
      mcnt_q   <= mcnt_d;
      tcnt_q   <= tcnt_d;
      mode_q   <= mode_d;
      rwmem_q  <= rwmem_d;
      kerr_q   <= kerr_d;
      tto_q    <= tto_d;
      active_q <= active_d;
      amem_q   <= amem_d;
      samp_q   <= samp_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.active     = active_q;
  assign bus.mode       = mode_q;
  assign bus.AccessMem  = amem_q;
  assign bus.RWMem      = rwmem_q;
  assign bus.SampleData = samp_q;
  assign bus.TxData     = txd_q;
  assign bus.Busy       = busy_q;
  assign bus.keyErr     = kerr_q;
  assign bus.txTimeout  = tto_q;

endmodule

// File: tb/tb_calc_controller_gen2.sv
// Bench for calc_controller_gen2: directed and random operations
// against a transaction-level expectation model, plus a wide-key instance.
module tb_calc_controller_gen2;

  localparam logic [3:0] KP   = 4'b1010;
  localparam int         TXTO = 16;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic exp_mode_a;

  calc_controller_gen2_if #(.MODE_W(1)) ia ();
  calc_controller_gen2_if #(.MODE_W(2)) ib ();

  calc_controller_gen2 #(
    .KEY_LEN(4), .KEY_PATTERN(4'b1010),
    .MODE_W(1), .TX_TIMEOUT(16)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ia)
  );

  calc_controller_gen2 #(
    .KEY_LEN(6), .KEY_PATTERN(6'b110010),
    .MODE_W(2), .TX_TIMEOUT(16)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic chk_a_zero(input string tag);
    chk({tag, "_act"},  ia.active, 0);
    chk({tag, "_mode"}, ia.mode, 0);
    chk({tag, "_amem"}, ia.AccessMem, 0);
    chk({tag, "_rwm"},  ia.RWMem, 0);
    chk({tag, "_samp"}, ia.SampleData, 0);
    chk({tag, "_tx"},   ia.TxData, 0);
    chk({tag, "_busy"}, ia.Busy, 0);
    chk({tag, "_kerr"}, ia.keyErr, 0);
    chk({tag, "_tto"},  ia.txTimeout, 0);
  endtask

  // One command on DUT A. done_at: TX edge carrying txDone
  // (0 or >TXTO = never). abort_at: edge (2..5) with validCmd=0.
  task automatic op_a(input logic [3:0] key, input logic md,
                      input logic rw, input int done_at,
                      input int abort_at);
    logic ok;
    logic b;
    int   end_at;
    logic tmo;
    ok = (key == KP);
    for (int e = 1; e <= 5; e++) begin
      b = (e <= 4) ? key[4-e] : md;
      ia.validCmd = (abort_at != e);
      ia.inputKey = ia.validCmd ? b : rb();
      ia.RW = (e == 5) ? rw : rb();
      tick();
      if (abort_at == e) begin
        chk("abort_busy", ia.Busy, 0);
        chk("abort_kerr", ia.keyErr, 0);
        chk("abort_act", ia.active, 0);
        chk("abort_mode", ia.mode, exp_mode_a);
        ia.validCmd = 1'b0;
        return;
      end
      if (e == 4 && !ok) begin
        chk("kerr_on", ia.keyErr, 1);
        chk("kerr_busy", ia.Busy, 0);
        chk("kerr_act", ia.active, 0);
        ia.validCmd = 1'b0;
        tick();
        chk("kerr_pulse", ia.keyErr, 0);
        chk("kerr_amem", ia.AccessMem, 0);
        return;
      end
      if (e < 5) begin
        chk("key_busy", ia.Busy, 1);
        chk("key_act", ia.active, 0);
        chk("key_kerr", ia.keyErr, 0);
        chk("key_mode", ia.mode, exp_mode_a);
      end
    end
    exp_mode_a = md;
    chk("lat_act", ia.active, 1);
    chk("lat_mode", ia.mode, md);
    chk("lat_busy", ia.Busy, 1);
    chk("lat_amem", ia.AccessMem, md);
    chk("lat_samp", ia.SampleData, !md);
    chk("lat_tx", ia.TxData, 0);
    if (md) chk("lat_rwm", ia.RWMem, rw);
    ia.validCmd = rb();
    ia.inputKey = rb();
    ia.RW = rb();
    tick();
    chk("step_amem", ia.AccessMem, 0);
    chk("step_samp", ia.SampleData, 0);
    if (md && rw) begin
      chk("wr_busy", ia.Busy, 0);
      chk("wr_tx", ia.TxData, 0);
      chk("wr_act", ia.active, 0);
      ia.validCmd = 1'b0;
      return;
    end
    chk("tx_on", ia.TxData, 1);
    chk("tx_act", ia.active, 1);
    end_at = (done_at >= 1 && done_at <= TXTO) ? done_at : TXTO;
    tmo = (end_at != done_at);
    for (int j = 1; j <= end_at; j++) begin
      ia.txDone = (j == done_at);
      ia.validCmd = rb();
      ia.inputKey = rb();
      tick();
      ia.txDone = 1'b0;
      if (j < end_at) begin
        chk("tx_hold", ia.TxData, 1);
        chk("tx_tto0", ia.txTimeout, 0);
      end
    end
    ia.validCmd = 1'b0;
    chk("tx_off", ia.TxData, 0);
    chk("tx_busy", ia.Busy, 0);
    chk("tx_actoff", ia.active, 0);
    chk("tx_tto", ia.txTimeout, tmo);
    chk("tx_mode", ia.mode, exp_mode_a);
    tick();
    chk("tto_pulse", ia.txTimeout, 0);
  endtask

  initial begin
    logic [4:0] ba;
    logic [7:0] bb;
    logic [3:0] rk;
    int         ab;
    checks = 0;
    failures = 0;
    exp_mode_a = 1'b0;
    ia.inputKey = 0; ia.validCmd = 0;
    ia.RW = 0; ia.txDone = 0;
    ib.inputKey = 0; ib.validCmd = 0;
    ib.RW = 0; ib.txDone = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_a_zero("rst");
    chk("rst_b_busy", ib.Busy, 0);
    chk("rst_b_mode", ib.mode, 0);

    op_a(4'b1010, 1, 0, 3, 0);
    op_a(4'b1010, 0, 0, 5, 0);
    op_a(4'b1001, 1, 0, 2, 0);
    op_a(4'b1010, 1, 0, 2, 0);
    op_a(4'b1010, 1, 1, 0, 0);
    op_a(4'b1010, 1, 0, 0, 0);
    op_a(4'b1010, 1, 0, 16, 0);
    op_a(4'b1010, 0, 0, 0, 0);
    op_a(4'b1010, 1, 0, 4, 3);
    op_a(4'b1010, 0, 0, 4, 5);
    op_a(4'b1010, 0, 0, 1, 0);

    for (int n = 0; n < 60; n++) begin
      rk = rb() ? KP : 4'($urandom_range(15, 0));
      ab = ($urandom_range(3, 0) == 0) ?
           int'($urandom_range(5, 2)) : 0;
      op_a(rk, rb(), rb(), int'($urandom_range(20, 0)), ab);
    end

    // Reset in the middle of TX clears everything.
    ba = 5'b10101;
    ia.RW = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      ia.validCmd = 1'b1;
      ia.inputKey = ba[i];
      tick();
    end
    ia.validCmd = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_tx", ia.TxData, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_mode_a = 1'b0;
    chk_a_zero("midrst");
    op_a(4'b1010, 1, 0, 2, 0);

    // Wide key, two-bit mode instance.
    bb = 8'b11001010;
    ib.RW = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      ib.validCmd = 1'b1;
      ib.inputKey = bb[i];
      tick();
      if (i == 1) chk("b_pre_act", ib.active, 0);
    end
    chk("b_act", ib.active, 1);
    chk("b_mode", ib.mode, 2);
    chk("b_amem", ib.AccessMem, 1);
    chk("b_rwm", ib.RWMem, 0);
    ib.validCmd = 1'b0;
    tick();
    chk("b_amem_off", ib.AccessMem, 0);
    chk("b_tx", ib.TxData, 1);
    ib.txDone = 1'b1;
    tick();
    ib.txDone = 1'b0;
    chk("b_busy", ib.Busy, 0);
    chk("b_txoff", ib.TxData, 0);
    chk("b_tto", ib.txTimeout, 0);
    chk("b_mode_keep", ib.mode, 2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_controller_gen2.md
Name: calc_controller_gen2

Overview:
- Parametrised second-generation control FSM for the binary calculator.
- Authenticates a serial key of configurable length and pattern on inputKey, then latches a multi-bit mode.
- Sequences either a memory access or a data sample, followed by a transmit handshake with a timeout.
- Sits between the key/command front end and the memory, sampler and TX blocks; reports key errors and TX timeouts.

Parameters:
- KEY_LEN, 4: number of key bits, shifted in MSB first.
- KEY_PATTERN, 4'b1010: expected key, width KEY_LEN.
- MODE_W, 1: number of mode bits, shifted in MSB first after the key.
- TX_TIMEOUT, 16: maximum number of cycles spent in TX waiting for txDone; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- inputKey  in  1  serial key/mode bit, sampled on each edge while validCmd=1.
- validCmd  in  1  qualifies inputKey during key and mode entry.
- RW  in  1  memory direction: 0=read, 1=write; sampled on the final mode edge.
- txDone  in  1  transmit complete from the TX block.
- active  out  1  high from mode latch until return to IDLE.
- mode  out  MODE_W  latched mode, held until the next mode latch or reset.
- AccessMem  out  1  one-cycle memory access strobe.
- RWMem  out  1  registered copy of RW, valid while AccessMem=1.
- SampleData  out  1  one-cycle sample strobe.
- TxData  out  1  high while in TX.
- Busy  out  1  high in every state except IDLE.
- keyErr  out  1  one-cycle pulse on key mismatch.
- txTimeout  out  1  one-cycle pulse on TX timeout.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. All outputs are 0, mode=0, state=IDLE, counters cleared. Reset asserted mid-operation forces the same state on the next edge, overriding every other input.
- States: IDLE, KEY, MODE, MEM, SAMPLE, TX. All outputs are registered or Moore-decoded from state.
- IDLE: on an edge with validCmd=1, shift inputKey in as key bit 1 and go to KEY.
- KEY: shift one bit per edge while validCmd=1. On the edge that captures bit KEY_LEN, compare the full key with KEY_PATTERN:
  - match: go to MODE.
  - mismatch: go to IDLE; keyErr=1 for the following cycle.
- KEY/MODE abort: validCmd=0 on any edge in KEY or MODE returns to IDLE with no keyErr. Partial shift registers are discarded.
- MODE: shift MODE_W bits. On the final edge:
  - latch mode and register RWMem<=RW.
  - active=1 from the next cycle.
  - next state MEM if the captured mode is nonzero, else SAMPLE.
- MEM: exactly one cycle with AccessMem=1. Then TX if RWMem=0 (read); IDLE if RWMem=1 (write).
- SAMPLE: exactly one cycle with SampleData=1, then TX.
- TX: TxData=1. A cycle counter starts at 0 on entry.
  - txDone=1 on an edge: go to IDLE.
  - otherwise, when TX_TIMEOUT>0 and the counter reaches TX_TIMEOUT-1: go to IDLE; txTimeout=1 for the following cycle.
  - txDone and timeout on the same edge: txDone wins, no txTimeout.
- Return to IDLE: active=0 and Busy=0 from the cycle after the edge that enters IDLE. mode retains its value.
- After a completed operation, IDLE accepts a new key on the next edge with validCmd=1. Key, mode and TX timing are unaffected by validCmd once the FSM has left MODE.
- Counter widths: $clog2(KEY_LEN+1), $clog2(MODE_W+1), $clog2(TX_TIMEOUT+1), each minimum 1. Counters saturate and never wrap.

Decomposition:
- Package calc_ctrl_pkg holds the state enum type ctrl_state_t and the default KEY_PATTERN/KEY_LEN constants.
- One sub-module, calc_key_matcher: key shift register, bit counter and comparator, with outputs done/match.
- The mode shift, the FSM and the TX timeout counter stay in the top module.

Test Plan:
- Reset, then validCmd=1 with key 1,0,1,0 and mode bit 1, RW=0, txDone=0 -> active=1 and mode=1 after edge 5; AccessMem=1 and RWMem=0 for one cycle; then TxData=1. Raise txDone -> Busy=0 one cycle later.
- Key 1,0,1,0 with mode 0 -> SampleData one-cycle pulse, then TxData=1 until txDone, with no AccessMem.
- Key 1,0,0,1 -> keyErr pulse one cycle after edge 4; no active or AccessMem; new correct key afterwards is accepted.
- Mode 1 with RW=1 -> AccessMem=1 and RWMem=1 for one cycle, then IDLE with no TxData.
- Mode 1, read, txDone held 0 with TX_TIMEOUT=16 -> TxData high exactly 16 cycles, txTimeout one-cycle pulse, Busy=0. Repeat with txDone=1 on the 16th edge -> no txTimeout.
- validCmd dropped after 2 key bits -> IDLE, no keyErr. Reset during TX -> all outputs 0 after the next edge. Rerun the first scenario with KEY_LEN=6, KEY_PATTERN=6'b110010, MODE_W=2, mode 2'b10.
